// File: rtl/seg_pkg.sv
// Shared definitions for the segment-file arbiter and the address calculator:
// register select codes, the EU segment encoding, FSM states and width defaults.
package seg_pkg;

  localparam int SEG_W_DEFAULT      = 16;
  localparam int ADDR_W_DEFAULT     = 20;
  localparam int STARVE_MAX_DEFAULT = 4;

  // Segment register file select codes.
  localparam logic [2:0] SEL_CS = 3'b000;
  localparam logic [2:0] SEL_DS = 3'b001;
  localparam logic [2:0] SEL_SS = 3'b010;
  localparam logic [2:0] SEL_ES = 3'b011;
  localparam logic [2:0] SEL_IP = 3'b100;

  // EU segment encoding; zero-extended it equals the select code.
  localparam logic [1:0] EU_CS = 2'b00;
  localparam logic [1:0] EU_DS = 2'b01;
  localparam logic [1:0] EU_SS = 2'b10;
  localparam logic [1:0] EU_ES = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_SEL   = 3'd2,
    ST_WAIT  = 3'd3,
    ST_ISSUE = 3'd4
  } state_e;

  // Codes 101..111 address nothing in the file.
  function automatic logic sel_valid(input logic [2:0] sel);
    return (sel <= SEL_IP);
  endfunction

endpackage

// File: rtl/seg_addr_calc.sv
// Combinational physical address former: (seg << 4) + off, truncated to
// ADDR_W so the sum wraps (FFFF:0010 -> 00000).
module seg_addr_calc
  import seg_pkg::*;
#(
  parameter int SEG_W  = SEG_W_DEFAULT,
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic [SEG_W-1:0]  seg,
  input  logic [SEG_W-1:0]  off,
  output logic [ADDR_W-1:0] addr
);

  logic [ADDR_W-1:0] seg_sh;
  logic [ADDR_W-1:0] off_ext;

  // Shift the segment by one nibble, extend the offset, add with wrap.
  always_comb begin
    seg_sh  = ADDR_W'({seg, 4'h0});
    off_ext = ADDR_W'(off);
    addr    = seg_sh + off_ext;
  end

endmodule

// File: rtl/seg_addr_arbiter.sv
// Arbiter/sequencer in front of the segment register file. Shares the file
// between segment writes, instruction fetch and EU data access, sequences the
// registered read and issues the physical address to memory.
//
// Handshakes: fetch_req/eu_req/wr_req are levels held until the matching
// one-cycle fetch_gnt/eu_gnt/wr_ack. Grants are decoded in IDLE from the live
// requests, so a requester sees its grant in the same cycle the arbiter
// commits. The memory side is valid/ready: mem_valid, mem_addr and mem_src
// stay stable until the cycle mem_valid & mem_ready are both high.
module seg_addr_arbiter
  import seg_pkg::*;
#(
  parameter int SEG_W      = SEG_W_DEFAULT,
  parameter int ADDR_W     = ADDR_W_DEFAULT,
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [SEG_W-1:0]  fetch_off,
  output logic              fetch_gnt,
  input  logic              eu_req,
  input  logic [1:0]        eu_seg,
  input  logic [SEG_W-1:0]  eu_off,
  output logic              eu_gnt,
  input  logic              wr_req,
  input  logic [2:0]        wr_sel,
  input  logic [SEG_W-1:0]  wr_data,
  output logic              wr_ack,
  output logic              seg_write_en,
  output logic [2:0]        seg_reg_select,
  output logic [SEG_W-1:0]  seg_wdata,
  input  logic [SEG_W-1:0]  seg_rdata,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_src,
  output logic              busy
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  starve_q, starve_d;
  logic [SEG_W-1:0]  off_q, off_d;
  logic              src_q, src_d;
  logic              wr_ack_q, wr_ack_d;
  logic              seg_write_en_q, seg_write_en_d;
  logic [2:0]        seg_reg_select_q, seg_reg_select_d;
  logic [SEG_W-1:0]  seg_wdata_q, seg_wdata_d;
  logic              mem_valid_q, mem_valid_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_src_q, mem_src_d;
  logic [ADDR_W-1:0] calc_addr;
  logic              fetch_win, eu_win;

  seg_addr_calc #(
    .SEG_W  (SEG_W),
    .ADDR_W (ADDR_W)
  ) u_calc (
    .seg  (seg_rdata),
    .off  (off_q),
    .addr (calc_addr)
  );

  // Read arbitration in IDLE: writes first, then EU unless a fetch has starved.
  always_comb begin
    fetch_win = 1'b0;
    eu_win    = 1'b0;
    if (!rst && state_q == ST_IDLE && !wr_req) begin
      if (eu_req && !(fetch_req && starve_q == CNT_MAX)) begin
        eu_win = 1'b1;
      end else if (fetch_req) begin
        fetch_win = 1'b1;
      end
    end
  end

  // Next-state and next-output computation for the sequencer.
  always_comb begin
    state_d          = state_q;
    starve_d         = starve_q;
    off_d            = off_q;
    src_d            = src_q;
    wr_ack_d         = 1'b0;
    seg_write_en_d   = 1'b0;
    seg_reg_select_d = seg_reg_select_q;
    seg_wdata_d      = seg_wdata_q;
    mem_valid_d      = mem_valid_q;
    mem_addr_d       = mem_addr_q;
    mem_src_d        = mem_src_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!fetch_req) starve_d = '0;
        if (wr_req) begin
          state_d          = ST_WRITE;
          wr_ack_d         = 1'b1;
          seg_write_en_d   = sel_valid(wr_sel);
          seg_reg_select_d = wr_sel;
          seg_wdata_d      = wr_data;
        end else if (eu_win) begin
          state_d          = ST_SEL;
          off_d            = eu_off;
          src_d            = 1'b1;
          seg_reg_select_d = {1'b0, eu_seg};
          if (fetch_req && starve_q != CNT_MAX) starve_d = starve_q + 1'b1;
        end else if (fetch_win) begin
          state_d          = ST_SEL;
          off_d            = fetch_off;
          src_d            = 1'b0;
          seg_reg_select_d = SEL_CS;
          starve_d         = '0;
        end
      end
      ST_WRITE: state_d = ST_IDLE;
      // The file captures seg_reg_select at the end of SEL; data arrives in WAIT.
      ST_SEL:   state_d = ST_WAIT;
      ST_WAIT: begin
        mem_addr_d  = calc_addr;
        mem_valid_d = 1'b1;
        mem_src_d   = src_q;
        state_d     = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (mem_ready) begin
          mem_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      starve_q         <= '0;
      off_q            <= '0;
      src_q            <= 1'b0;
      wr_ack_q         <= 1'b0;
      seg_write_en_q   <= 1'b0;
      seg_reg_select_q <= '0;
      seg_wdata_q      <= '0;
      mem_valid_q      <= 1'b0;
      mem_addr_q       <= '0;
      mem_src_q        <= 1'b0;
    end else begin
      state_q          <= state_d;
      starve_q         <= starve_d;
      off_q            <= off_d;
      src_q            <= src_d;
      wr_ack_q         <= wr_ack_d;
      seg_write_en_q   <= seg_write_en_d;
      seg_reg_select_q <= seg_reg_select_d;
      seg_wdata_q      <= seg_wdata_d;
      mem_valid_q      <= mem_valid_d;
      mem_addr_q       <= mem_addr_d;
      mem_src_q        <= mem_src_d;
    end
  end

  assign fetch_gnt      = fetch_win;
  assign eu_gnt         = eu_win;
  assign wr_ack         = wr_ack_q;
  assign seg_write_en   = seg_write_en_q;
  assign seg_reg_select = seg_reg_select_q;
  assign seg_wdata      = seg_wdata_q;
  assign mem_valid      = mem_valid_q;
  assign mem_addr       = mem_addr_q;
  assign mem_src        = mem_src_q;
  assign busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_seg_addr_arbiter.sv
// Directed bench for seg_addr_arbiter with a behavioural segment file and an
// expected-address queue ({src, addr}) checked at each memory transfer.
module tb_seg_addr_arbiter;
  import seg_pkg::*;

  localparam int SEG_W      = 16;
  localparam int ADDR_W     = 20;
  localparam int STARVE_MAX = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              fetch_req;
  logic [SEG_W-1:0]  fetch_off;
  logic              fetch_gnt;
  logic              eu_req;
  logic [1:0]        eu_seg;
  logic [SEG_W-1:0]  eu_off;
  logic              eu_gnt;
  logic              wr_req;
  logic [2:0]        wr_sel;
  logic [SEG_W-1:0]  wr_data;
  logic              wr_ack;
  logic              seg_write_en;
  logic [2:0]        seg_reg_select;
  logic [SEG_W-1:0]  seg_wdata;
  logic [SEG_W-1:0]  seg_rdata = '0;
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_src;
  logic              busy;

  int checks = 0;
  int errors = 0;
  logic [ADDR_W:0]  exp_q[$];
  logic [SEG_W-1:0] exp_seg  [0:7] = '{default: '0};
  logic [SEG_W-1:0] file_regs[0:7] = '{default: '0};

  seg_addr_arbiter #(
    .SEG_W(SEG_W), .ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_off(fetch_off), .fetch_gnt(fetch_gnt),
    .eu_req(eu_req), .eu_seg(eu_seg), .eu_off(eu_off), .eu_gnt(eu_gnt),
    .wr_req(wr_req), .wr_sel(wr_sel), .wr_data(wr_data), .wr_ack(wr_ack),
    .seg_write_en(seg_write_en), .seg_reg_select(seg_reg_select),
    .seg_wdata(seg_wdata), .seg_rdata(seg_rdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_src(mem_src), .busy(busy)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Segment register file: write on write_en, registered read of reg_select.
  always @(posedge clk) begin
    if (seg_write_en && seg_reg_select <= 3'd4) file_regs[seg_reg_select] <= seg_wdata;
    seg_rdata <= (seg_reg_select <= 3'd4) ? file_regs[seg_reg_select] : '0;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver: segment write through the arbiter.
  task automatic do_write(input logic [2:0] sel, input logic [SEG_W-1:0] data);
    int n;
    @(negedge clk);
    wr_req = 1'b1; wr_sel = sel; wr_data = data;
    n = 0;
    do begin @(negedge clk); #1; n++; end while (!wr_ack && n < 20);
    chk("wr_ack_seen", 32'(wr_ack), 1);
    chk("wr_ack_latency", 32'(n), 1);
    chk("wr_write_en", 32'(seg_write_en), (sel <= 3'd4) ? 1 : 0);
    if (sel <= 3'd4) begin
      chk("wr_select", 32'(seg_reg_select), 32'(sel));
      chk("wr_data", 32'(seg_wdata), 32'(data));
      exp_seg[sel] = data;
    end
    wr_req = 1'b0;
    @(negedge clk); #1;
    chk("wr_ack_pulse", 32'(wr_ack), 0);
    chk("wr_en_pulse", 32'(seg_write_en), 0);
  endtask

  // Driver: raise a read request, wait for its grant, push expected address.
  task automatic read_req(input logic src, input logic [1:0] sg, input logic [SEG_W-1:0] off);
    int n;
    logic [2:0] code;
    logic [ADDR_W-1:0] a;
    @(negedge clk);
    if (src) begin eu_req = 1'b1; eu_seg = sg; eu_off = off; end
    else begin fetch_req = 1'b1; fetch_off = off; end
    #1; n = 0;
    while (!(src ? eu_gnt : fetch_gnt) && n < 20) begin @(negedge clk); #1; n++; end
    chk("read_grant", 32'(src ? eu_gnt : fetch_gnt), 1);
    chk("other_grant_quiet", 32'(src ? fetch_gnt : eu_gnt), 0);
    code = src ? {1'b0, sg} : SEL_CS;
    a = {exp_seg[code], 4'h0} + {4'h0, off};
    exp_q.push_back({src, a});
  endtask

  // From the grant cycle: check latency, stalls, transfer and return to IDLE.
  task automatic complete_read(input int ready_wait);
    logic [ADDR_W:0] e;
    @(negedge clk); #1;
    fetch_req = 1'b0; eu_req = 1'b0;
    chk("sel_no_valid", 32'(mem_valid), 0);
    chk("sel_busy", 32'(busy), 1);
    @(negedge clk); #1;
    chk("wait_no_valid", 32'(mem_valid), 0);
    @(negedge clk); #1;
    chk("issue_valid_3cyc", 32'(mem_valid), 1);
    chk("sb_nonempty", 32'(exp_q.size() > 0), 1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    for (int k = 0; k < ready_wait; k++) begin
      chk("stall_valid", 32'(mem_valid), 1);
      chk("stall_addr", 32'(mem_addr), 32'(e[ADDR_W-1:0]));
      chk("stall_src", 32'(mem_src), 32'(e[ADDR_W]));
      @(negedge clk); #1;
    end
    mem_ready = 1'b1;
    chk("xfer_valid", 32'(mem_valid), 1);
    chk("xfer_addr", 32'(mem_addr), 32'(e[ADDR_W-1:0]));
    chk("xfer_src", 32'(mem_src), 32'(e[ADDR_W]));
    @(negedge clk); #1;
    mem_ready = 1'b0;
    chk("done_valid_low", 32'(mem_valid), 0);
    chk("done_not_busy", 32'(busy), 0);
  endtask

  initial begin
    logic [5:0] pat;
    logic [ADDR_W:0] e;
    logic [ADDR_W-1:0] a;
    logic drop_f;
    logic drop_e;
    int ng;
    int cyc;
    logic [1:0] rs;
    logic [SEG_W-1:0] ro;

    rst = 1'b1; fetch_req = 1'b0; fetch_off = '0; eu_req = 1'b0; eu_seg = '0; eu_off = '0;
    wr_req = 1'b0; wr_sel = '0; wr_data = '0; mem_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_mem_valid", 32'(mem_valid), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_wr_ack", 32'(wr_ack), 0);
    chk("rst_write_en", 32'(seg_write_en), 0);
    chk("rst_select", 32'(seg_reg_select), 0);
    rst = 1'b0;

    // CS = F000, fetch at FFF0 -> FFFF0
    do_write(SEL_CS, 16'hF000);
    read_req(1'b0, 2'b00, 16'hFFF0);
    complete_read(0);

    // DS = FFFF, EU DS:0010 wraps to 00000
    do_write(SEL_DS, 16'hFFFF);
    read_req(1'b1, EU_DS, 16'h0010);
    complete_read(0);

    // SS read held off by mem_ready for 5 cycles
    do_write(SEL_SS, 16'h2000);
    read_req(1'b1, EU_SS, 16'h0345);
    complete_read(5);

    // ES and CS through the EU path, IP write
    do_write(SEL_ES, 16'hABCD);
    read_req(1'b1, EU_ES, 16'h1111);
    complete_read(2);
    read_req(1'b1, EU_CS, 16'h0001);
    complete_read(1);
    do_write(SEL_IP, 16'h5555);

    // A few random EU reads
    for (int i = 0; i < 4; i++) begin
      rs = 2'($urandom_range(0, 3));
      ro = 16'($urandom_range(0, 16'hFFFF));
      read_req(1'b1, rs, ro);
      complete_read($urandom_range(0, 3));
    end

    // Fetch starvation: EU held with fetch pending -> 4 EU grants, then fetch
    @(negedge clk);
    mem_ready = 1'b1;
    fetch_req = 1'b1; fetch_off = 16'h0100;
    eu_req = 1'b1; eu_seg = EU_DS; eu_off = 16'h0020;
    #1;
    pat = '0; ng = 0; cyc = 0; drop_f = 1'b0; drop_e = 1'b0;
    while ((ng < 6 || exp_q.size() > 0) && cyc < 200) begin
      if (drop_f) begin fetch_req = 1'b0; drop_f = 1'b0; end
      if (drop_e) begin eu_req = 1'b0; drop_e = 1'b0; end
      if (eu_gnt) begin
        a = {exp_seg[SEL_DS], 4'h0} + {4'h0, eu_off};
        exp_q.push_back({1'b1, a});
        pat = {pat[4:0], 1'b1}; ng++;
        if (!fetch_req) drop_e = 1'b1;
      end
      if (fetch_gnt) begin
        a = {exp_seg[SEL_CS], 4'h0} + {4'h0, fetch_off};
        exp_q.push_back({1'b0, a});
        pat = {pat[4:0], 1'b0}; ng++;
        drop_f = 1'b1;
      end
      if (mem_valid && mem_ready) begin
        e = exp_q.pop_front();
        chk("starve_xfer_addr", 32'(mem_addr), 32'(e[ADDR_W-1:0]));
        chk("starve_xfer_src", 32'(mem_src), 32'(e[ADDR_W]));
      end
      @(negedge clk); #1; cyc++;
    end
    fetch_req = 1'b0; eu_req = 1'b0; mem_ready = 1'b0;
    chk("starve_in_budget", 32'(cyc < 200), 1);
    chk("starve_grant_order", 32'(pat), 32'(6'b111101));

    // Counter restarted: both requesting again -> EU first
    @(negedge clk);
    fetch_req = 1'b1; fetch_off = 16'h0200;
    eu_req = 1'b1; eu_seg = EU_ES; eu_off = 16'h0002;
    #1;
    chk("restart_eu_first", 32'(eu_gnt), 1);
    chk("restart_fetch_wait", 32'(fetch_gnt), 0);
    a = {exp_seg[SEL_ES], 4'h0} + {4'h0, 16'h0002};
    exp_q.push_back({1'b1, a});
    complete_read(0);

    // Write to CS and fetch in the same cycle: write first, fetch sees it
    @(negedge clk);
    wr_req = 1'b1; wr_sel = SEL_CS; wr_data = 16'h1234;
    fetch_req = 1'b1; fetch_off = 16'h0005;
    #1;
    chk("wr_beats_fetch", 32'(fetch_gnt), 0);
    @(negedge clk); #1;
    chk("wrf_ack", 32'(wr_ack), 1);
    chk("wrf_write_en", 32'(seg_write_en), 1);
    chk("wrf_select", 32'(seg_reg_select), 0);
    chk("wrf_data", 32'(seg_wdata), 32'h1234);
    chk("wrf_no_gnt_in_write", 32'(fetch_gnt), 0);
    wr_req = 1'b0;
    exp_seg[SEL_CS] = 16'h1234;
    @(negedge clk); #1;
    chk("wrf_fetch_gnt", 32'(fetch_gnt), 1);
    exp_q.push_back({1'b0, 20'h12345});
    complete_read(0);

    // Reset in ISSUE aborts the transfer
    read_req(1'b1, EU_ES, 16'h0004);
    @(negedge clk); #1;
    eu_req = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    chk("abort_valid_before", 32'(mem_valid), 1);
    rst = 1'b1;
    @(negedge clk); #1;
    chk("abort_valid", 32'(mem_valid), 0);
    chk("abort_addr", 32'(mem_addr), 0);
    chk("abort_src", 32'(mem_src), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_grants", 32'(fetch_gnt | eu_gnt | wr_ack), 0);
    chk("abort_select", 32'(seg_reg_select), 0);
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    rst = 1'b0;

    // Out-of-range select: ack without a write
    do_write(3'b110, 16'hBEEF);

    chk("sb_empty", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_addr_arbiter.md
Name: seg_addr_arbiter

Overview:
Arbiter and sequencer in front of the segment register file (CS/DS/SS/ES/IP, registered read, write-enable + 3-bit select).
- Shares the file among three requesters: segment writes from the execution unit, instruction fetch (CS-based) and EU data access (DS/SS/ES).
- Sequences each read and forms the 20-bit physical address, (segment << 4) + offset.
- Presents the address to memory with a valid/ready handshake.

Parameters:
SEG_W, 16, segment and offset width
ADDR_W, 20, physical address width
STARVE_MAX, 4, consecutive EU grants after which a pending fetch is forced ahead

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
fetch_req  in  1  fetch request; level, held until fetch_gnt
fetch_off  in  SEG_W  fetch offset (IP), sampled at grant
fetch_gnt  out  1  one-cycle grant pulse
eu_req  in  1  EU data request; level, held until eu_gnt
eu_seg  in  2  segment for EU access: 00 CS, 01 DS, 10 SS, 11 ES
eu_off  in  SEG_W  EU offset, sampled at grant
eu_gnt  out  1  one-cycle grant pulse
wr_req  in  1  segment write request; level, held until wr_ack
wr_sel  in  3  target register: 000 CS, 001 DS, 010 SS, 011 ES, 100 IP
wr_data  in  SEG_W  write value
wr_ack  out  1  one-cycle acknowledge
seg_write_en  out  1  to segment file write_en
seg_reg_select  out  3  to segment file reg_select
seg_wdata  out  SEG_W  to segment file data
seg_rdata  in  SEG_W  from segment file Data_Segment
mem_valid  out  1  physical address valid
mem_ready  in  1  memory accepts the address
mem_addr  out  ADDR_W  physical address
mem_src  out  1  0 = fetch, 1 = EU
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (synchronous): every output is 0, state = IDLE, starve counter = 0. Reset asserted in any state aborts the transaction; mem_valid is 0 from the following cycle; no grant or ack is issued.
- FSM states: IDLE, WRITE, SEL, WAIT, ISSUE.
- IDLE, priority order:
  - wr_req: go to WRITE.
  - Otherwise eu_req, unless fetch_req and starve counter == STARVE_MAX.
  - Otherwise fetch_req.
  - On a read grant: pulse fetch_gnt or eu_gnt; latch the offset; latch the select code ({0, eu_seg} for EU, 000 for fetch); latch the source; go to SEL.
- WRITE, one cycle:
  - seg_write_en = 1, seg_reg_select = wr_sel, seg_wdata = wr_data, wr_ack = 1.
  - Return to IDLE.
  - wr_sel 101–111: wr_ack still pulses, seg_write_en stays 0.
- SEL: seg_write_en = 0 and seg_reg_select = latched code; go to WAIT. The file updates Data_Segment at this edge.
- WAIT: seg_rdata is valid in this cycle. Register mem_addr = ({4'b0, seg} << 4) + {4'b0, off}, truncated to ADDR_W, so it wraps modulo 2^20 (FFFF:0010 -> 00000). Set mem_valid = 1, mem_src = latched source. Go to ISSUE.
- ISSUE:
  - mem_valid, mem_addr and mem_src are held stable while mem_ready = 0.
  - On mem_valid & mem_ready: mem_valid = 0 next cycle, return to IDLE.
  - No new grant is issued in the cycle the transfer completes.
- Latency: grant cycle (IDLE) -> SEL -> WAIT -> mem_valid asserted in the next cycle; 3 cycles from grant to first mem_valid.
- Starve counter:
  - +1 on each EU grant while fetch_req = 1, saturating at STARVE_MAX.
  - Cleared on fetch grant, or when fetch_req = 0 in IDLE.
- seg_reg_select holds its last value outside SEL/WRITE. seg_write_en is 1 only in WRITE.
- A write to CS issued before a pending fetch is granted is visible to that fetch.

Decomposition:
- Package seg_pkg: select codes CS/DS/SS/ES/IP (3'b000..3'b100), the 2-bit eu_seg encoding, FSM state enum, SEG_W/ADDR_W defaults.
- Sub-module seg_addr_calc (combinational): (seg, off) -> 20-bit physical address, wrap by truncation. Reused later by the prefetch queue.

Test Plan:
- CS = F000, fetch_req with fetch_off = FFF0 -> fetch_gnt pulse, mem_valid 3 cycles later, mem_addr = FFFF0, mem_src = 0.
- DS = FFFF, eu_req eu_seg = 01, eu_off = 0010 -> mem_addr = 00000 (wrap), mem_src = 1.
- fetch_req and eu_req in the same cycle, eu held -> EU granted 4 times (STARVE_MAX), then fetch granted; counter returns to 0.
- wr_req (CS <- 1234) and fetch_req (off 0005) in the same cycle -> wr_ack first with seg_write_en = 1, seg_reg_select = 000; fetch then yields mem_addr = 12345.
- mem_ready held 0 for 5 cycles in ISSUE -> mem_valid and mem_addr stable throughout; ready = 1 -> mem_valid = 0 the next cycle, busy = 0.
- rst asserted in ISSUE -> all outputs 0 the next cycle. Then a write with wr_sel = 110 -> wr_ack = 1, seg_write_en = 0.
